// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: FSM state encoding and default key codes.
// Both the code-entry front end and the lock checker import this package.
package lock_pkg;

    localparam int unsigned KEY_W = 4;

    // Entry FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } lock_state_e;

    // Default keypad codes for the clear and enter keys
    localparam logic [KEY_W-1:0] KEY_CLR_DEF = 4'hC;
    localparam logic [KEY_W-1:0] KEY_ENT_DEF = 4'hE;

    // True for decimal digit keys 0-9
    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/lock_code_entry_if.sv
// Keypad / checker-side signal bundle of the code entry block.
//  master : keypad scanner and checker side (drives keys and code_ready)
//  slave  : lock_code_entry (drives the assembled code and status)
//  key_valid/key_code : key strobe and code
//  code_out/code_valid/code_ready : code handshake to the checker
//  digit_cnt/entry_active/short_err/timeout_err : status and error pulses
interface lock_code_entry_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   code_out;
    logic                  code_valid;
    logic                  code_ready;
    logic [3:0]            digit_cnt;
    logic                  entry_active;
    logic                  short_err;
    logic                  timeout_err;

    modport master (
        output key_valid, key_code, code_ready,
        input  code_out, code_valid, digit_cnt, entry_active, short_err, timeout_err
    );

    modport slave (
        input  key_valid, key_code, code_ready,
        output code_out, code_valid, digit_cnt, entry_active, short_err, timeout_err
    );
endinterface

// File: rtl/lock_idle_timer.sv
// Inactivity timer for code entry. Counts cycles while run_i is high, restarts
// on restart_i, clears while not running and saturates at TIMEOUT_CYC-1.
//  clk, rst_n  : clock, async active-low reset
//  run_i       : count enable (entry in progress)
//  restart_i   : accepted key this cycle, restart from zero
//  expire_c_o  : combinational, high while running with the count at its last value
module lock_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic restart_i,
    output logic expire_c_o
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: clear when idle or restarted, otherwise count up and hold at LAST
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || restart_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/lock_code_entry.sv
// Keypad front end of the combination lock: collects BCD digits into a code
// word and presents it to the checker over valid/ready. Handles clear, enter,
// short entries and inactivity timeout.
//  clk, rst_n : clock, async active-low reset
//  bus        : lock_code_entry_if slave (key strobe in, code handshake and status out)
module lock_code_entry
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [3:0]  KEY_CLR     = KEY_CLR_DEF,
    parameter logic [3:0]  KEY_ENT     = KEY_ENT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    lock_code_entry_if.slave bus
);

    localparam int unsigned CODE_W   = 4 * DIGITS;
    localparam logic [3:0]  FULL_CNT = 4'(DIGITS);

    lock_state_e       state_q;
    logic [CODE_W-1:0] code_q;
    logic [3:0]        cnt_q;
    logic              valid_q;
    logic              active_q;
    logic              short_q;
    logic              tout_q;

    logic              key_digit_c;
    logic              key_clr_c;
    logic              key_ent_c;
    logic              restart_c;
    logic              run_c;
    logic              expire_c;
    logic [CODE_W+3:0] code_ext_c;
    logic [CODE_W-1:0] code_shift_c;

    assign key_digit_c = bus.key_valid && is_digit(bus.key_code);
    assign key_clr_c   = bus.key_valid && (bus.key_code == KEY_CLR);
    assign key_ent_c   = bus.key_valid && (bus.key_code == KEY_ENT);

    // New digit enters at the low nibble, oldest digit falls off the top
    assign code_ext_c   = {code_q, bus.key_code};
    assign code_shift_c = code_ext_c[CODE_W-1:0];

    // Any recognised key restarts the idle timer; unknown codes do not
    assign run_c     = (state_q == ST_COLLECT);
    assign restart_c = (state_q == ST_IDLE    && key_digit_c) ||
                       (state_q == ST_COLLECT && (key_digit_c || key_clr_c || key_ent_c));

    lock_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run_c),
        .restart_i  (restart_c),
        .expire_c_o (expire_c)
    );

    // Entry FSM with registered outputs; a key in the expiry cycle takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            short_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            short_q <= 1'b0;
            tout_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_digit_c) begin
                        code_q   <= CODE_W'(bus.key_code);
                        cnt_q    <= 4'd1;
                        active_q <= 1'b1;
                        state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (key_digit_c) begin
                        if (cnt_q < FULL_CNT) begin
                            code_q <= code_shift_c;
                            cnt_q  <= cnt_q + 4'd1;
                        end
                    end else if (key_clr_c) begin
                        code_q   <= '0;
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (key_ent_c) begin
                        active_q <= 1'b0;
                        if (cnt_q == FULL_CNT) begin
                            valid_q <= 1'b1;
                            state_q <= ST_PRESENT;
                        end else begin
                            short_q <= 1'b1;
                            code_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else if (expire_c) begin
                        tout_q   <= 1'b1;
                        code_q   <= '0;
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_PRESENT: begin
                    if (valid_q && bus.code_ready) begin
                        valid_q <= 1'b0;
                        code_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.code_out     = code_q;
    assign bus.code_valid   = valid_q;
    assign bus.digit_cnt    = cnt_q;
    assign bus.entry_active = active_q;
    assign bus.short_err    = short_q;
    assign bus.timeout_err  = tout_q;

endmodule

// File: tb/tb_lock_code_entry.sv
// Bench for lock_code_entry (DIGITS=2, TIMEOUT_CYC=8): directed vector table,
// hand-written timeout/reset sequences, and random keys against a queue model.
module tb_lock_code_entry;

    localparam int unsigned D  = 2;
    localparam int unsigned TO = 8;
    localparam logic [3:0]  K_CLR = 4'hC;
    localparam logic [3:0]  K_ENT = 4'hE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lock_code_entry_if #(.DIGITS(D)) bus ();

    lock_code_entry #(
        .DIGITS      (D),
        .TIMEOUT_CYC (TO),
        .KEY_CLR     (K_CLR),
        .KEY_ENT     (K_ENT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       rdy;
        logic [7:0] code;
        logic [3:0] cnt;
        logic       val;
        logic       act;
        logic       sh;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic kv, input logic [3:0] kc, input logic rdy,
                               input logic [7:0] code, input logic [3:0] cnt,
                               input logic val, input logic act, input logic sh, input logic to);
        vec_t r;
        r.kv = kv; r.kc = kc; r.rdy = rdy; r.code = code; r.cnt = cnt;
        r.val = val; r.act = act; r.sh = sh; r.to = to;
        return r;
    endfunction

    task automatic drive(input logic kv, input logic [3:0] kc, input logic rdy);
        bus.key_valid  = kv;
        bus.key_code   = kc;
        bus.code_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] code, input logic [3:0] cnt,
                         input logic val, input logic act, input logic sh, input logic to);
        logic [15:0] got;
        logic [15:0] want;
        got  = {bus.code_out, bus.digit_cnt, bus.code_valid, bus.entry_active,
                bus.short_err, bus.timeout_err};
        want = {code, cnt, val, act, sh, to};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got code=%h cnt=%0d valid=%b active=%b short=%b tout=%b, want code=%h cnt=%0d valid=%b active=%b short=%b tout=%b",
                     name, $time, bus.code_out, bus.digit_cnt, bus.code_valid, bus.entry_active,
                     bus.short_err, bus.timeout_err, code, cnt, val, act, sh, to);
        end
    endtask

    // Reference model: digits held in a queue, idle cycles counted since the last key
    int  m_q[$];
    bit  m_coll;
    bit  m_pres;
    int  m_idle;

    task automatic m_reset();
        m_q.delete();
        m_coll = 0;
        m_pres = 0;
        m_idle = 0;
    endtask

    function automatic logic [7:0] m_code();
        int acc = 0;
        foreach (m_q[i]) acc = acc * 16 + m_q[i];
        return 8'(acc);
    endfunction

    task automatic m_step(input logic kv, input logic [3:0] kc, input logic rdy,
                          output logic sh, output logic to);
        bit is_dig;
        bit known;
        is_dig = kv && (kc <= 4'd9);
        known  = is_dig || (kv && (kc == K_CLR || kc == K_ENT));
        sh = 1'b0;
        to = 1'b0;
        if (m_pres) begin
            if (rdy) begin
                m_pres = 0;
                m_q.delete();
            end
        end else if (m_coll) begin
            if (known) begin
                m_idle = 0;
                if (is_dig) begin
                    if (m_q.size() < int'(D)) m_q.push_back(int'(kc));
                end else if (kc == K_CLR) begin
                    m_q.delete();
                    m_coll = 0;
                end else begin
                    m_coll = 0;
                    if (m_q.size() == int'(D)) begin
                        m_pres = 1;
                    end else begin
                        sh = 1'b1;
                        m_q.delete();
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == int'(TO)) begin
                    to = 1'b1;
                    m_q.delete();
                    m_coll = 0;
                end
            end
        end else if (is_dig) begin
            m_q.delete();
            m_q.push_back(int'(kc));
            m_coll = 1;
            m_idle = 0;
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        logic sh;
        logic to;
        int   dense;

        drive(1'b0, 4'h0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed vectors: inputs for one edge and the outputs expected after it
        // keys 1,0,ENT with ready high
        tbl.push_back(v(1, 4'h1, 1, 8'h01, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'h0, 1, 8'h10, 2, 0, 1, 0, 0));
        tbl.push_back(v(1, K_ENT, 1, 8'h10, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
        // keys 5,ENT: short entry
        tbl.push_back(v(1, 4'h5, 0, 8'h05, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, K_ENT, 0, 8'h00, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
        // CLR and ENT in IDLE are ignored
        tbl.push_back(v(1, K_ENT, 1, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, K_CLR, 1, 8'h00, 0, 0, 0, 0, 0));
        // keys 1,2,3,ENT then ready held low
        tbl.push_back(v(1, 4'h1, 0, 8'h01, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'h2, 0, 8'h12, 2, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'h3, 0, 8'h12, 2, 0, 1, 0, 0));
        tbl.push_back(v(1, K_ENT, 0, 8'h12, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 0, 8'h12, 2, 1, 0, 0, 0));
        tbl.push_back(v(1, 4'h7, 0, 8'h12, 2, 1, 0, 0, 0));
        tbl.push_back(v(1, K_CLR, 0, 8'h12, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 0, 8'h12, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 0, 8'h12, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));
        // keys A,4,B,CLR,9,F,9,ENT
        tbl.push_back(v(1, 4'hA, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'h4, 0, 8'h04, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'hB, 0, 8'h04, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, K_CLR, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'h9, 0, 8'h09, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'hF, 0, 8'h09, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'h9, 0, 8'h99, 2, 0, 1, 0, 0));
        tbl.push_back(v(1, K_ENT, 1, 8'h99, 2, 1, 0, 0, 0));
        tbl.push_back(v(0, 4'h0, 1, 8'h00, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].kv, tbl[i].kc, tbl[i].rdy);
            tick();
            check($sformatf("vec%0d", i), tbl[i].code, tbl[i].cnt, tbl[i].val,
                  tbl[i].act, tbl[i].sh, tbl[i].to);
        end

        // Timeout: key 7 then 8 idle cycles, pulse on the 8th
        drive(1'b1, 4'h7, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            check($sformatf("idle%0d", i), 8'h07, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check("timeout_pulse", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("timeout_after", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Key in the expiry cycle wins
        drive(1'b1, 4'h7, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        repeat (int'(TO) - 1) tick();
        drive(1'b1, 4'h3, 1'b0);
        tick();
        check("key_wins", 8'h73, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        tick();
        check("key_wins_next", 8'h73, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, K_CLR, 1'b0);
        tick();
        check("clr_after_wins", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while presenting
        drive(1'b1, 4'h1, 1'b0); tick();
        drive(1'b1, 4'h2, 1'b0); tick();
        drive(1'b1, K_ENT, 1'b0); tick();
        check("pre_reset_present", 8'h12, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset%0d", i), 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Random keys against the reference model; density alternates to hit timeouts
        do_reset();
        dense = 1;
        for (int n = 0; n < 4000; n++) begin
            logic       kv;
            logic [3:0] kc;
            logic       rdy;
            if (n % 40 == 0) dense = int'($urandom_range(0, 1));
            kv  = dense != 0 ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
            kc  = 4'($urandom_range(0, 15));
            rdy = 1'($urandom_range(0, 1));
            drive(kv, kc, rdy);
            m_step(kv, kc, rdy, sh, to);
            tick();
            check("rand", m_code(), 4'(m_q.size()), m_pres, m_coll, sh, to);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
